// File: rtl/alu_pkg.sv
// Shared types for the execute-ALU arbiter: ALU select codes, result-register state, port ids.
// Pure declarations, no logic.
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_NOP = 2'b11
    } alu_sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    typedef logic port_id_t;

    function automatic logic [1:0] port_onehot(input port_id_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/ALU/response bundle of the ALU arbiter; slave = arbiter side, master = environment.
// Pure wiring, no latency; flow control is valid/ready on both request and response.
interface alu_arbiter_if #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [XLEN-1:0]  req_a0;
    logic [XLEN-1:0]  req_b0;
    logic [XLEN-1:0]  req_a1;
    logic [XLEN-1:0]  req_b1;
    logic [1:0]       req_sel0;
    logic [1:0]       req_sel1;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [1:0]       alu_sel;
    logic [XLEN-1:0]  alu_out;
    logic             alu_cout;
    logic             alu_z;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [XLEN-1:0]  rsp_data;
    logic             rsp_cout;
    logic             rsp_z;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1,
        output req_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_cout, alu_z,
        output rsp_valid, rsp_data, rsp_cout, rsp_z,
        input  rsp_ready,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1,
        input  req_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_cout, alu_z,
        input  rsp_valid, rsp_data, rsp_cout, rsp_z,
        output rsp_ready,
        input  grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter, round-robin or fixed (port 0 first); combinational, zero latency.
// enable low forces no grant, which is how the caller applies downstream backpressure.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic [1:0] grant
);
    logic [1:0] cand;

    always_comb begin
        cand  = valid & {2{enable}};
        grant = cand;
        // On contention, round-robin favours the port that did not win last time.
        if (cand == 2'b11) begin
            grant = (rr_en && !last_grant) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute ALU between EX (port 0) and branch/addr-calc (port 1); result 1 cycle after accept.
// One-deep result register: no new accept until the tagged requester takes the held result.
module alu_arbiter #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    import alu_pkg::*;

    localparam logic RR_BIT = (RR_EN != 0);

    arb_state_t       state;
    port_id_t         tag;
    port_id_t         last_grant;
    logic [XLEN-1:0]  data_q;
    logic             cout_q;
    logic             z_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic [1:0]       grant;
    logic             fire;
    logic             can_accept;
    logic             accept;
    port_id_t         gport;
    logic [XLEN-1:0]  mux_a;
    logic [XLEN-1:0]  mux_b;
    alu_sel_t         mux_sel;

    // Only the tagged port's ready counts; the other bit is ignored.
    assign fire       = (state == FULL) && bus.rsp_ready[tag];
    assign can_accept = (state == EMPTY) || fire;

    rr_arb2 u_arb (
        .valid      (bus.req_valid),
        .enable     (can_accept),
        .last_grant (last_grant),
        .rr_en      (RR_BIT),
        .grant      (grant)
    );

    assign accept = |grant;
    assign gport  = port_id_t'(grant[1]);

    // Idle ALU inputs are held at zero / NOP so the datapath does not toggle.
    always_comb begin
        mux_a   = '0;
        mux_b   = '0;
        mux_sel = ALU_NOP;
        if (grant[0]) begin
            mux_a   = bus.req_a0;
            mux_b   = bus.req_b0;
            mux_sel = alu_sel_t'(bus.req_sel0);
        end else if (grant[1]) begin
            mux_a   = bus.req_a1;
            mux_b   = bus.req_b1;
            mux_sel = alu_sel_t'(bus.req_sel1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            tag        <= 1'b0;
            last_grant <= 1'b1;
            data_q     <= '0;
            cout_q     <= 1'b0;
            z_q        <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else if (accept) begin
            state      <= FULL;
            tag        <= gport;
            last_grant <= gport;
            data_q     <= bus.alu_out;
            cout_q     <= bus.alu_cout;
            z_q        <= bus.alu_z;
            if (grant[0]) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end else begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end else if (fire) begin
            state <= EMPTY;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.alu_a      = mux_a;
    assign bus.alu_b      = mux_b;
    assign bus.alu_sel    = mux_sel;
    assign bus.rsp_valid  = (state == FULL) ? port_onehot(tag) : 2'b00;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_z      = z_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: round-robin instance (CNT_W=4) plus a fixed-priority twin fed identical requests.
module tb_alu_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    alu_arbiter_if #(.XLEN(64), .CNT_W(4))  r ();
    alu_arbiter_if #(.XLEN(64), .CNT_W(16)) f ();

    alu_arbiter #(.XLEN(64), .RR_EN(1), .CNT_W(4)) u_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (r)
    );

    alu_arbiter #(.XLEN(64), .RR_EN(0), .CNT_W(16)) u_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: {z, cout, out}
    function automatic logic [65:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] s);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (s)
            2'b00:   return {a == b, 1'b0, a & b};
            2'b01:   return {a == b, 1'b0, a | b};
            2'b10:   return {a == b, sum[64], sum[63:0]};
            default: return {a == b, 1'b0, 64'h0};
        endcase
    endfunction

    always_comb {r.alu_z, r.alu_cout, r.alu_out} = alu_f(r.alu_a, r.alu_b, r.alu_sel);
    always_comb {f.alu_z, f.alu_cout, f.alu_out} = alu_f(f.alu_a, f.alu_b, f.alu_sel);

    assign f.req_valid = r.req_valid;
    assign f.req_a0    = r.req_a0;
    assign f.req_b0    = r.req_b0;
    assign f.req_a1    = r.req_a1;
    assign f.req_b1    = r.req_b1;
    assign f.req_sel0  = r.req_sel0;
    assign f.req_sel1  = r.req_sel1;
    assign f.rsp_ready = r.rsp_ready;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset       = 1'b1;
        r.req_valid = 2'b00;
        r.req_a0    = '0;
        r.req_b0    = '0;
        r.req_a1    = '0;
        r.req_b1    = '0;
        r.req_sel0  = 2'b00;
        r.req_sel1  = 2'b00;
        r.rsp_ready = 2'b00;
        step();
        step();

        check_val("rst_rsp_valid", 64'(r.rsp_valid), 64'h0);
        check_val("rst_rsp_data",  r.rsp_data, 64'h0);
        check_val("rst_rsp_cout",  64'(r.rsp_cout), 64'h0);
        check_val("rst_rsp_z",     64'(r.rsp_z), 64'h0);
        check_val("rst_cnt0",      64'(r.grant_cnt0), 64'h0);
        check_val("rst_cnt1",      64'(r.grant_cnt1), 64'h0);
        check_val("rst_alu_sel",   64'(r.alu_sel), 64'h3);

        // Single request on port 0: 5 + 3
        reset       = 1'b0;
        r.req_valid = 2'b01;
        r.req_a0    = 64'h5;
        r.req_b0    = 64'h3;
        r.req_sel0  = 2'b10;
        r.rsp_ready = 2'b01;
        #1;
        check_val("add_req_ready", 64'(r.req_ready), 64'h1);
        check_val("add_alu_a",     r.alu_a, 64'h5);
        step();
        r.req_valid = 2'b00;
        check_val("add_rsp_valid", 64'(r.rsp_valid), 64'h1);
        check_val("add_rsp_data",  r.rsp_data, 64'h8);
        check_val("add_rsp_cout",  64'(r.rsp_cout), 64'h0);
        check_val("add_rsp_z",     64'(r.rsp_z), 64'h0);
        check_val("add_cnt0",      64'(r.grant_cnt0), 64'h1);

        // Contention, both results consumed every cycle
        reset = 1'b1;
        step();
        reset       = 1'b0;
        r.req_valid = 2'b11;
        r.req_a0    = 64'hF0;
        r.req_b0    = 64'hFF;
        r.req_sel0  = 2'b00;
        r.req_a1    = 64'h0F;
        r.req_b1    = 64'hF0;
        r.req_sel1  = 2'b01;
        r.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("rr_req_ready", 64'(r.req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            check_val("fp_req_ready", 64'(f.req_ready), 64'h1);
            step();
            check_val("rr_rsp_valid", 64'(r.rsp_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
            check_val("rr_rsp_data",  r.rsp_data, (i % 2 == 0) ? 64'hF0 : 64'hFF);
            check_val("fp_rsp_data",  f.rsp_data, 64'hF0);
        end
        check_val("rr_cnt0", 64'(r.grant_cnt0), 64'h2);
        check_val("rr_cnt1", 64'(r.grant_cnt1), 64'h2);
        check_val("fp_cnt0", 64'(f.grant_cnt0), 64'h4);
        check_val("fp_cnt1", 64'(f.grant_cnt1), 64'h0);
        r.req_valid = 2'b00;
        step();

        // Carry-out, then back-to-back equality on port 1
        r.req_valid = 2'b10;
        r.req_a1    = 64'hFFFF_FFFF_FFFF_FFFF;
        r.req_b1    = 64'h1;
        r.req_sel1  = 2'b10;
        r.rsp_ready = 2'b10;
        #1;
        check_val("carry_req_ready", 64'(r.req_ready), 64'h2);
        step();
        check_val("carry_rsp_valid", 64'(r.rsp_valid), 64'h2);
        check_val("carry_rsp_data",  r.rsp_data, 64'h0);
        check_val("carry_rsp_cout",  64'(r.rsp_cout), 64'h1);
        check_val("carry_rsp_z",     64'(r.rsp_z), 64'h0);
        r.req_a1   = 64'h1234;
        r.req_b1   = 64'h1234;
        r.req_sel1 = 2'b00;
        #1;
        check_val("eq_req_ready", 64'(r.req_ready), 64'h2);
        step();
        check_val("eq_rsp_data", r.rsp_data, 64'h1234);
        check_val("eq_rsp_z",    64'(r.rsp_z), 64'h1);
        check_val("eq_rsp_cout", 64'(r.rsp_cout), 64'h0);
        r.req_valid = 2'b00;
        step();

        // Backpressure: port 0 result held while both ports request
        r.req_valid = 2'b01;
        r.req_a0    = 64'hF0;
        r.req_b0    = 64'hFF;
        r.req_sel0  = 2'b00;
        r.rsp_ready = 2'b00;
        step();
        r.req_valid = 2'b11;
        r.req_a1    = 64'h0F;
        r.req_b1    = 64'hF0;
        r.req_sel1  = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_req_ready", 64'(r.req_ready), 64'h0);
            step();
            check_val("bp_rsp_valid", 64'(r.rsp_valid), 64'h1);
            check_val("bp_rsp_data",  r.rsp_data, 64'hF0);
        end
        r.rsp_ready = 2'b01;
        #1;
        check_val("bp_release_ready", 64'(r.req_ready), 64'h2);
        step();
        check_val("bp_next_valid", 64'(r.rsp_valid), 64'h2);
        check_val("bp_next_data",  r.rsp_data, 64'hFF);
        r.req_valid = 2'b00;
        r.rsp_ready = 2'b00;
        step();

        // Reset while FULL
        reset = 1'b1;
        step();
        check_val("mid_rsp_valid", 64'(r.rsp_valid), 64'h0);
        check_val("mid_rsp_data",  r.rsp_data, 64'h0);
        check_val("mid_cnt0",      64'(r.grant_cnt0), 64'h0);
        check_val("mid_cnt1",      64'(r.grant_cnt1), 64'h0);
        reset       = 1'b0;
        r.req_valid = 2'b11;
        r.rsp_ready = 2'b11;
        #1;
        check_val("mid_first_grant", 64'(r.req_ready), 64'h1);
        step();
        check_val("mid_first_valid", 64'(r.rsp_valid), 64'h1);
        r.req_valid = 2'b00;
        step();

        // NOP select: result zero, equality still reported
        r.req_valid = 2'b10;
        r.req_a1    = 64'h77;
        r.req_b1    = 64'h77;
        r.req_sel1  = 2'b11;
        step();
        r.req_valid = 2'b00;
        check_val("nop_rsp_data", r.rsp_data, 64'h0);
        check_val("nop_rsp_z",    64'(r.rsp_z), 64'h1);
        step();

        // Counter wrap at CNT_W=4
        reset = 1'b1;
        step();
        reset       = 1'b0;
        r.req_valid = 2'b01;
        r.rsp_ready = 2'b01;
        for (int i = 0; i < 17; i++) begin
            step();
        end
        r.req_valid = 2'b00;
        check_val("wrap_cnt0", 64'(r.grant_cnt0), 64'h1);
        check_val("wrap_cnt1", 64'(r.grant_cnt1), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
